// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ producers.
// One requester holds the port for a burst of at most MAX_BURST accepted beats.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            wr_clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic                            fifo_full,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            wr_en,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [$clog2(NUM_REQ)-1:0]      active_id,
  output logic                            busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  state_t                next_state;
  logic [NUM_REQ-1:0]    next_grant;
  logic [ID_W-1:0]       next_id;
  logic [ID_W-1:0]       rr_last;
  logic [ID_W-1:0]       next_rr_last;
  logic [ID_W-1:0]       sel;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      next_count;
  logic                  found;
  logic                  act_req;
  logic                  act_last;
  logic [DATA_WIDTH-1:0] act_data;
  logic                  beat;
  logic                  done;

  // Signals of the currently granted requester
  always_comb begin
    act_req  = 1'b0;
    act_last = 1'b0;
    act_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == active_id) begin
        act_req  = req[i];
        act_last = req_last[i];
        act_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Circular scan: indices above rr_last first, then wrap to 0..rr_last
  always_comb begin
    sel   = rr_last;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) > rr_last)) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) <= rr_last)) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
  end

  // Next-state and beat logic
  always_comb begin
    next_state   = state;
    next_grant   = grant;
    next_id      = active_id;
    next_count   = count;
    next_rr_last = rr_last;
    beat         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          next_state = BURST;
          next_grant = NUM_REQ'(1) << sel;
          next_id    = sel;
          next_count = '0;
        end
      end
      BURST: begin
        beat = act_req & ~fifo_full;
        done = (beat & (act_last | (count == CNT_W'(MAX_BURST - 1)))) | ~act_req;
        if (beat) begin
          next_count = count + CNT_W'(1);
        end
        if (done) begin
          next_state   = IDLE;
          next_grant   = '0;
          next_rr_last = active_id;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      active_id <= '0;
      count     <= '0;
      rr_last   <= ID_W'(NUM_REQ - 1);
    end else begin
      state     <= next_state;
      grant     <= next_grant;
      active_id <= next_id;
      count     <= next_count;
      rr_last   <= next_rr_last;
    end
  end

  // Write port follows the current full flag only; data is zero outside a burst
  assign busy    = (state == BURST);
  assign wr_en   = beat;
  assign ack     = grant & {NUM_REQ{beat}};
  assign wr_data = busy ? act_data : '0;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers in the wr_clk domain.
- Grants one requester at a time for a bounded burst.
- Drives FIFO wr_en/wr_data; stalls on the registered write-side full flag.
- Sits between the producer blocks and the FIFO write-pointer/memory logic.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- DATA_WIDTH, 8: FIFO word width.
- MAX_BURST, 4: maximum accepted beats per grant; range 1..16.

Ports:
- wr_clk  input  1  write-domain clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; level, held while data is valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final beat of requester i's packet.
- fifo_full  input  1  registered full flag from the FIFO write side.
- grant  output  NUM_REQ  one-hot registered grant; all-zero when idle.
- ack  output  NUM_REQ  beat accepted this cycle; one-hot or zero, combinational.
- wr_en  output  1  FIFO write enable, combinational.
- wr_data  output  DATA_WIDTH  granted requester's data; zero when idle.
- active_id  output  clog2(NUM_REQ)  index of the granted requester; valid when busy=1.
- busy  output  1  high in BURST state.

Behaviour:
Reset (async):
- State = IDLE; grant = 0; active_id = 0; busy = 0.
- Burst counter = 0; rr_last = NUM_REQ-1, so requester 0 wins first.

FSM:
- IDLE:
  - If req != 0, select the first set req bit scanning circularly from rr_last+1.
  - On the next edge: grant <= onehot(sel), active_id <= sel, count <= 0, state <= BURST.
  - Otherwise remain in IDLE.
- BURST:
  - beat = req[active_id] & !fifo_full.
  - wr_en = beat; ack[active_id] = beat; wr_data = req_data slice of active_id.
  - count increments on each beat.
- Return to IDLE (grant cleared, rr_last <= active_id) on the edge where any of:
  - (a) beat & req_last[active_id];
  - (b) beat & count == MAX_BURST-1;
  - (c) req[active_id] == 0, no beat this cycle.

Timing:
- Request in cycle N gives grant in N+1. First wr_en in N+1 if FIFO is not full.
- One idle cycle between consecutive grants.
- Sustained rate: up to MAX_BURST beats per MAX_BURST+1 cycles.

Full handling:
- fifo_full=1 in BURST: wr_en=0, ack=0, count holds, grant holds. No timeout.
- Full rising in the same cycle as a beat: that beat is not issued. wr_en is gated by the current fifo_full only.

Boundary conditions:
- req_last and count limit coincide: single exit, no double count.
- Non-granted req changes during BURST are ignored until IDLE.
- Granted req drops while full: condition (c) exits with no write.
- rst mid-burst: outputs clear immediately (async); a partial packet is the producer's concern.
- req_data of non-granted requesters never reaches wr_data.
- Counter width: clog2(MAX_BURST+1).

Invariants:
- wr_en implies exactly one ack bit set, and it matches grant.
- grant is one-hot or zero.

Test Plan:
- Single requester: req=0001, req_last on beat 3, full=0 -> grant=0001 one cycle later; wr_en for 3 consecutive cycles with data D0..D2; then IDLE for 1 cycle; grant=0.
- Round-robin: req=1111 held, never last, MAX_BURST=4 -> grant sequence 0001,0010,0100,1000,0001; each grant yields exactly 4 wr_en pulses.
- Full stall: fifo_full=1 for 3 cycles mid-burst after beat 1 -> wr_en=0 and ack=0 for those cycles, grant held; remaining beats resume; total 4 beats.
- Request drop: granted req deasserts after 2 beats -> IDLE next edge; rr_last updated; next requester in order granted.
- Reset mid-burst: assert rst asynchronously between edges during beat 2 -> grant, wr_en and busy go 0 immediately; after release, req=1111 grants 0001 first.
- Priority fairness: requester 2 finishes its burst, then req=0101 -> requester 0 is granted (scan starts at index 3, wraps to 0).
